// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used across the core and its memory-side blocks.
// Also carries the data-memory responder's state and captured-request types.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic      rd;
        logic      wr;
        logic      oor;
        logic [3:0] be;
        rv32i_word wdata;
    } dmem_req_t;

    // True when any byte-address bit above the word index is set.
    function automatic logic addr_out_of_range(input rv32i_word addr, input int addr_w);
        return (addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enable and a registered read port.
// Contents are not reset; the read register only loads on a read access.
module dmem_array
    import rv32i_types::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic              re,
    input  rv32i_word         wdata,
    output rv32i_word         rdata
);

    rv32i_word mem_q [2**ADDR_W];
    rv32i_word rdata_q;

    // Byte-lane write and registered read both happen on the single access edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: captures one request, waits LATENCY edges,
// accesses the array and pulses mem_resp (with mem_err for bad requests) for one cycle.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    input  rv32i_word  mem_address,
    input  rv32i_word  mem_wdata,
    input  logic [3:0] mem_byte_enable,
    output logic       mem_resp,
    output rv32i_word  mem_rdata,
    output logic       mem_err
);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dmem_req_t         req_q, req_d;
    logic              resp_q, resp_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;

    logic [3:0]        arr_we_s;
    logic              arr_re_s;
    rv32i_word         arr_rdata_s;

    // Next-state, capture and array-access decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        req_d    = req_q;
        resp_d   = 1'b0;
        err_d    = 1'b0;
        rvalid_d = rvalid_q;
        arr_we_s = 4'b0000;
        arr_re_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d    = mem_address[ADDR_W+1:2];
                    req_d.rd  = mem_read;
                    req_d.wr  = mem_write;
                    req_d.oor = addr_out_of_range(mem_address, ADDR_W);
                    req_d.be  = mem_byte_enable;
                    req_d.wdata = mem_wdata;
                    count_d   = CNT_INIT;
                    state_d   = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    err_d   = req_q.oor | (req_q.rd & req_q.wr);
                    // A read that also writes is treated as a write only.
                    if (!req_q.oor) begin
                        arr_we_s = req_q.wr ? req_q.be : 4'b0000;
                        arr_re_s = req_q.rd & ~req_q.wr;
                    end else begin
                        arr_we_s = 4'b0000;
                        arr_re_s = 1'b0;
                    end
                    if (req_q.rd && !req_q.wr) begin
                        rvalid_d = ~req_q.oor;
                    end else begin
                        rvalid_d = rvalid_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, captured request and response flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= {CNT_W{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            req_q    <= '0;
            resp_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .addr  (addr_q),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .wdata (req_q.wdata),
        .rdata (arr_rdata_s)
    );

    // The array read register has no reset, so its value is masked until a good read lands.
    assign mem_rdata = rvalid_q ? arr_rdata_s : 32'd0;
    assign mem_resp  = resp_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for function checks,
// one LATENCY=1 instance for back-to-back response spacing.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd2, wr2, resp2, err2;
    logic [31:0] addr2, wd2, rdata2;
    logic [3:0]  be2;
    logic        rd1, wr1, resp1, err1;
    logic [31:0] addr1, wd1, rdata1;
    logic [3:0]  be1;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .mem_read(rd2), .mem_write(wr2),
        .mem_address(addr2), .mem_wdata(wd2), .mem_byte_enable(be2),
        .mem_resp(resp2), .mem_rdata(rdata2), .mem_err(err2)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
        .mem_address(addr1), .mem_wdata(wd1), .mem_byte_enable(be1),
        .mem_resp(resp1), .mem_rdata(rdata1), .mem_err(err1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request on dut2, scramble inputs after capture, wait for mem_resp.
    task automatic req2(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int          lat;
        logic        e;
        logic [31:0] rdv;
        lat = 0;
        e   = 1'b0;
        rdv = 32'd0;
        @(negedge clk);
        rd2 = rd; wr2 = wr; addr2 = a; wd2 = wd; be2 = be;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp2) begin
                lat = i;
                e   = err2;
                rdv = rdata2;
                break;
            end
            if (i == 1) begin
                wd2   = ~wd;
                addr2 = a ^ 32'h0000_0004;
                be2   = ~be;
            end
        end
        check_val({tag, "_lat"}, lat, 32'd3);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        check_val({tag, "_rdata"}, rdv, exp_rdata);
        @(negedge clk);
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'd0; wd2 = 32'd0; be2 = 4'h0;
        @(posedge clk);
        #1;
        check_val({tag, "_resp_single"}, {31'd0, resp2}, 32'd0);
        check_val({tag, "_err_idle"}, {31'd0, err2}, 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] hist;
        rst = 1'b0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 32'd0; wd2 = 32'd0; be2 = 4'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0; be1 = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_resp", {31'd0, resp2}, 32'd0);
        check_val("rst_err", {31'd0, err2}, 32'd0);
        check_val("rst_rdata", rdata2, 32'd0);
        check_val("rst_resp1", {31'd0, resp1}, 32'd0);
        rst = 1'b1;

        req2("wr_full",  1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000);
        req2("rd_full",  1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF);
        req2("wr_lane1", 1'b0, 1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 1'b0, 32'hDEAD_BEEF);
        req2("rd_lane1", 1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_AAEF);
        req2("wr_w0",    1'b0, 1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 1'b0, 32'hDEAD_AAEF);
        req2("rd_oor",   1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0000_0000);
        req2("rd_w0",    1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h0102_0304);
        req2("both",     1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b1, 32'h0102_0304);
        req2("rd_both",  1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 32'h1234_5678);
        req2("wr_be0",   1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h1234_5678);
        req2("rd_be0",   1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 32'h1234_5678);
        req2("wr_oor",   1'b0, 1'b1, 32'h8000_0010, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h1234_5678);
        req2("rd_alias", 1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_AAEF);

        // Reset while the request is in BUSY: it must vanish without a response.
        @(negedge clk);
        rd2 = 1'b1; addr2 = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd2 = 1'b0;
        #1;
        check_val("midrst_resp", {31'd0, resp2}, 32'd0);
        check_val("midrst_rdata", rdata2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | resp2;
        end
        check_val("midrst_no_resp", {31'd0, seen}, 32'd0);
        req2("rd_after_rst", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_AAEF);

        // Held read on LATENCY=1: pulses every third cycle, never two in a row.
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h0000_0000;
        hist = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            hist[i] = resp1;
        end
        rd1 = 1'b0;
        check_val("b2b_pattern", {24'd0, hist}, 32'h0000_0092);
        check_val("b2b_no_consec", {24'd0, hist & (hist >> 1)}, 32'd0);
        check_val("b2b_err", {31'd0, err1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
